vga_timing_gen: RTL and testbench
=================================

Name:
vga_timing_gen

Overview:
- Raster timing source for the 640x480@60 display path; it sits at the producer end of the pixel-coordinate interface that the game renderers consume.
- Divides the 100 MHz system clock to a 25 MHz pixel rate and runs the horizontal and vertical counters.
- Generates active-low hSync/vSync and the bright display-area flag.
- Emits single-cycle frame and vertical-blank ticks that pace paddle, ball and block-state updates.

Parameters:
- CLK_DIV, 4: system clocks per pixel (1 = every clock is a pixel).
- H_TOTAL, 800: pixels per line.
- H_SYNC, 96: hSync low width, starting at hCount=0.
- H_DISP_START, 144: first visible hCount.
- H_DISP_END, 784: first non-visible hCount after the active area.
- V_TOTAL, 525: lines per frame.
- V_SYNC, 2: vSync low width, starting at vCount=0.
- V_DISP_START, 35: first visible vCount.
- V_DISP_END, 515: first non-visible vCount after the active area.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- pix_en  out  1  one-clk pulse marking each pixel step.
- hCount  out  10  horizontal position, 0..H_TOTAL-1.
- vCount  out  10  vertical position, 0..V_TOTAL-1.
- hSync  out  1  horizontal sync, active-low.
- vSync  out  1  vertical sync, active-low.
- bright  out  1  1 inside the visible 640x480 area.
- frame_tick  out  1  one-clk pulse at frame start.
- vblank_tick  out  1  one-clk pulse at the start of vertical blanking.

Behaviour:
- Reset is asynchronous on rst low. All outputs and internal state clear immediately:
  - div_cnt=0, hCount=0, vCount=0.
  - hSync=0 and vSync=0, which is correct because (0,0) lies inside both sync pulses.
  - bright=0, pix_en=0, frame_tick=0, vblank_tick=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en=1 for the clk cycle in which div_cnt==CLK_DIV-1; it is 0 in all other cycles.
  - With CLK_DIV=1, pix_en=1 every cycle after reset release.
- Counters advance only on clocks where pix_en=1.
  - hCount increments and wraps H_TOTAL-1 -> 0.
  - On each hCount wrap, vCount increments and wraps V_TOTAL-1 -> 0.
  - Both counters hold their values between pix_en pulses.
- All decoded outputs are registered and computed from the next counter values, so they are aligned with hCount/vCount in the same cycle and have zero skew relative to the counters.
  - hSync = 0 iff hCount < H_SYNC.
  - vSync = 0 iff vCount < V_SYNC.
  - bright = 1 iff H_DISP_START <= hCount < H_DISP_END and V_DISP_START <= vCount < V_DISP_END. The visible corners are (144,35) and (783,514).
- Ticks:
  - frame_tick is high for exactly one clk, in the first cycle in which the counters read (0,0) after a wrap. It is not asserted coming out of reset.
  - vblank_tick is high for exactly one clk, in the first cycle in which the counters read (0,V_DISP_END).
  - Both ticks are otherwise 0. They never coincide, because V_DISP_END != 0.
- Counter widths are 10 bits. Parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024. Comparisons are unsigned.
- Reset asserted mid-frame immediately returns every output to its reset value. Timing restarts from (0,0) on the first pix_en after release, with no partial tick.
- Steady-state periods:
  - One line = H_TOTAL*CLK_DIV clks = 3200.
  - One frame = 800*525*4 = 1,680,000 clks.

Test Plan:
- Reset and release: hold rst=0 for 10 clks. Require hCount=vCount=0, hSync=vSync=0, bright=0 and all ticks 0 throughout. After release, the first pix_en occurs on the 4th clk and hCount becomes 1 on that clk.
- Horizontal timing: run one line. Require hSync low for exactly 384 clks (hCount 0..95), hCount to reach 799 and wrap to 0, and vCount to step 0->1 on that same wrap edge.
- Display window: check the corners.
  - bright=1 at (144,35), (783,35), (144,514) and (783,514).
  - bright=0 at (143,35), (784,35), (144,34) and (144,515).
  - bright=0 in all cycles where vCount<35.
- Frame timing: run 2 frames.
  - vSync low for exactly 2 lines = 6400 clks.
  - frame_tick pulses once per 1,680,000 clks, each pulse 1 clk wide, at (0,0).
  - vblank_tick pulses once per frame at (0,515).
- Mid-frame reset: assert rst=0 at (400,200) during a pix_en cycle. Require all outputs to reach reset values asynchronously before the next clk edge, and the counters to restart cleanly from 0 with no spurious tick.
- CLK_DIV=1 build: pix_en stays high continuously; the line period is 800 clks and the frame period is 420,000 clks.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate and raster timing bundle driven by vga_timing_gen and read by the renderers.
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic       frame_tick;
  logic       vblank_tick;

  modport master (
    output pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, vblank_tick
  );

  modport slave (
    input pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, vblank_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-rate divider, h/v counters, registered syncs, display window and frame ticks.
module vga_timing_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_DISP_START = 144,
  parameter int H_DISP_END   = 784,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC       = 2,
  parameter int V_DISP_START = 35,
  parameter int V_DISP_END   = 515
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SW    = 10'(H_SYNC);
  localparam logic [9:0] V_SW    = 10'(V_SYNC);
  localparam logic [9:0] H_DS    = 10'(H_DISP_START);
  localparam logic [9:0] H_DE    = 10'(H_DISP_END);
  localparam logic [9:0] V_DS    = 10'(V_DISP_START);
  localparam logic [9:0] V_DE    = 10'(V_DISP_END);

  logic [DW-1:0] div_cnt, div_next;
  logic          pix_en_q;
  logic [9:0]    h_cnt, v_cnt, h_next, v_next;
  logic          hsync_q, vsync_q, bright_q, frame_q, vblank_q;
  logic          at_origin_next;

  assign div_next = (div_cnt == DIV_MAX) ? '0 : div_cnt + DW'(1);

  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (pix_en_q) begin
      if (h_cnt == H_MAX) begin
        h_next = '0;
        v_next = (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
      end else begin
        h_next = h_cnt + 10'd1;
      end
    end
  end

  // Ticks require an actual pixel step, so leaving reset at (0,0) never fires one.
  assign at_origin_next = pix_en_q && (h_next == 10'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      pix_en_q <= 1'b0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      bright_q <= 1'b0;
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      div_cnt  <= div_next;
      pix_en_q <= (div_next == DIV_MAX);
      h_cnt    <= h_next;
      v_cnt    <= v_next;
      hsync_q  <= (h_next >= H_SW);
      vsync_q  <= (v_next >= V_SW);
      bright_q <= (h_next >= H_DS) && (h_next < H_DE) && (v_next >= V_DS) && (v_next < V_DE);
      frame_q  <= at_origin_next && (v_next == 10'd0);
      vblank_q <= at_origin_next && (v_next == V_DE);
    end
  end

  assign vga.pix_en      = pix_en_q;
  assign vga.hCount      = h_cnt;
  assign vga.vCount      = v_cnt;
  assign vga.hSync       = hsync_q;
  assign vga.vSync       = vsync_q;
  assign vga.bright      = bright_q;
  assign vga.frame_tick  = frame_q;
  assign vga.vblank_tick = vblank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, CLK_DIV=1 and shrunken-geometry builds against a closed-form raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if bus_def ();
  vga_timing_gen_if bus_one ();
  vga_timing_gen_if bus_sml ();

  vga_timing_gen u_def (.clk(clk), .rst(rst), .vga(bus_def));
  vga_timing_gen #(.CLK_DIV(1)) u_one (.clk(clk), .rst(rst), .vga(bus_one));
  vga_timing_gen #(
    .CLK_DIV(4), .H_TOTAL(20), .H_SYNC(3), .H_DISP_START(5), .H_DISP_END(17),
    .V_TOTAL(12), .V_SYNC(2), .V_DISP_START(3), .V_DISP_END(10)
  ) u_sml (.clk(clk), .rst(rst), .vga(bus_sml));

  logic [25:0] obs_def, obs_one, obs_sml;
  assign obs_def = {bus_def.pix_en, bus_def.hSync, bus_def.vSync, bus_def.bright,
                    bus_def.frame_tick, bus_def.vblank_tick, bus_def.hCount, bus_def.vCount};
  assign obs_one = {bus_one.pix_en, bus_one.hSync, bus_one.vSync, bus_one.bright,
                    bus_one.frame_tick, bus_one.vblank_tick, bus_one.hCount, bus_one.vCount};
  assign obs_sml = {bus_sml.pix_en, bus_sml.hSync, bus_sml.vSync, bus_sml.bright,
                    bus_sml.frame_tick, bus_sml.vblank_tick, bus_sml.hCount, bus_sml.vCount};

  int total = 0;
  int bad   = 0;
  int k     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (k=%0d t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  // k = rising edges since reset release; pixel n advances on the edge after each pix_en cycle.
  function automatic logic [25:0] model(input int kk, input int div, input int ht, input int hs,
                                        input int hds, input int hde, input int vt, input int vs,
                                        input int vds, input int vde);
    int n, np, h, v;
    logic pix, adv;
    n   = (div == 1) ? ((kk >= 1) ? kk - 1 : 0) : kk / div;
    np  = (kk == 0) ? 0 : ((div == 1) ? ((kk >= 2) ? kk - 2 : 0) : (kk - 1) / div);
    adv = (n != np);
    pix = (kk >= 1) && ((kk % div) == div - 1);
    h   = n % ht;
    v   = (n / ht) % vt;
    return {pix, 1'(h >= hs), 1'(v >= vs), 1'(h >= hds && h < hde && v >= vds && v < vde),
            1'(adv && h == 0 && v == 0), 1'(adv && h == 0 && v == vde), 10'(h), 10'(v)};
  endfunction

  task automatic cmp_all();
    check("def", 32'(obs_def), 32'(model(k, 4, 800, 96, 144, 784, 525, 2, 35, 515)));
    check("one", 32'(obs_one), 32'(model(k, 1, 800, 96, 144, 784, 525, 2, 35, 515)));
    check("sml", 32'(obs_sml), 32'(model(k, 4, 20, 3, 5, 17, 12, 2, 3, 10)));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) k++;
    #1;
  endtask

  // Small-build display corners: {h, v, expected bright}
  int corner_h [8] = '{5, 16, 5, 16, 4, 17, 5, 5};
  int corner_v [8] = '{3, 3, 9, 9, 3, 3, 2, 10};
  int corner_b [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  bit corner_done [8];

  initial begin
    int first_pix, h_at4, hs_low, h_max, prev_h_def, prev_h_one, wraps_one, one_pix_low;
    int one_wrap0, one_wrap1, ft_cnt, vb_cnt, ft_prev, ft_period, vs_run, vs_last, corners_seen;
    bit wrap_seen;
    first_pix = -1; h_at4 = -1; hs_low = 0; h_max = 0; prev_h_def = 0; prev_h_one = 0;
    wraps_one = 0; one_pix_low = 0; one_wrap0 = 0; one_wrap1 = 0; ft_cnt = 0; vb_cnt = 0;
    ft_prev = -1; ft_period = 0; vs_run = 0; vs_last = 0; corners_seen = 0; wrap_seen = 0;

    for (int i = 0; i < 10; i++) begin
      step();
      cmp_all();
    end
    rst = 1'b1;

    for (int c = 0; c < 7163; c++) begin
      step();
      cmp_all();
      if (first_pix < 0 && bus_def.pix_en) first_pix = k;
      if (k == 4) h_at4 = int'(bus_def.hCount);
      if (bus_def.vCount == 10'd1 && !bus_def.hSync) hs_low++;
      if (int'(bus_def.hCount) > h_max) h_max = int'(bus_def.hCount);
      if (!wrap_seen && prev_h_def == 799 && bus_def.hCount == 10'd0) begin
        check("v_step_wrap", 32'(bus_def.vCount), 32'd1);
        wrap_seen = 1'b1;
      end
      prev_h_def = int'(bus_def.hCount);
      if (!bus_one.pix_en) one_pix_low++;
      if (prev_h_one == 799 && bus_one.hCount == 10'd0) begin
        if (wraps_one == 0) one_wrap0 = k;
        if (wraps_one == 1) one_wrap1 = k;
        wraps_one++;
      end
      prev_h_one = int'(bus_one.hCount);
      if (bus_sml.frame_tick) begin
        if (ft_prev >= 0) ft_period = k - ft_prev;
        ft_prev = k;
        ft_cnt++;
      end
      if (bus_sml.vblank_tick) vb_cnt++;
      if (!bus_sml.vSync) vs_run++;
      else if (vs_run > 0) begin
        vs_last = vs_run;
        vs_run  = 0;
      end
      for (int p = 0; p < 8; p++) begin
        if (!corner_done[p] && int'(bus_sml.hCount) == corner_h[p] && int'(bus_sml.vCount) == corner_v[p]) begin
          check($sformatf("corner_%0d_%0d", corner_h[p], corner_v[p]), 32'(bus_sml.bright), 32'(corner_b[p]));
          corner_done[p] = 1'b1;
          corners_seen++;
        end
      end
    end

    check("first_pix_edge", 32'(first_pix), 32'd3);
    check("h_after_first_pix", 32'(h_at4), 32'd1);
    check("hsync_low_clks", 32'(hs_low), 32'd384);
    check("h_max", 32'(h_max), 32'd799);
    check("wrap_seen", 32'(wrap_seen), 32'd1);
    check("one_pix_low", 32'(one_pix_low), 32'd0);
    check("one_line_period", 32'(one_wrap1 - one_wrap0), 32'd800);
    check("sml_frame_ticks", 32'(ft_cnt), 32'd7);
    check("sml_frame_period", 32'(ft_period), 32'd960);
    check("sml_vblank_ticks", 32'(vb_cnt), 32'd7);
    check("sml_vsync_low", 32'(vs_last), 32'd160);
    check("corners_seen", 32'(corners_seen), 32'd8);

    // Small build sits at (10,5) in a pix_en cycle here; reset lands mid-cycle.
    check("mid_pix", 32'(bus_sml.pix_en), 32'd1);
    check("mid_h", 32'(bus_sml.hCount), 32'd10);
    check("mid_v", 32'(bus_sml.vCount), 32'd5);
    rst = 1'b0;
    k   = 0;
    #1;
    check("async_def", 32'(obs_def), 32'd0);
    check("async_one", 32'(obs_one), 32'd0);
    check("async_sml", 32'(obs_sml), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      cmp_all();
    end
    rst = 1'b1;

    ft_cnt = 0;
    vb_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      step();
      cmp_all();
      if (bus_sml.frame_tick) ft_cnt++;
      if (bus_sml.vblank_tick) vb_cnt++;
    end
    check("post_rst_frame_ticks", 32'(ft_cnt), 32'd1);
    check("post_rst_vblank_ticks", 32'(vb_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
